// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshake pipeline stage register.
// Contents:
//   stage_state_t - occupancy state of a stage (empty / one entry / two entries)
//   DATA_W_DEF    - default data payload width
//   CTRL_W_DEF    - default control payload width
//   CTRL_BUBBLE_BIT - value every control bit takes on a bubble
//   state_to_occ  - maps a stage state to its 2-bit occupancy count
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 16;

  // Control bits of a bubble are all zero so a downstream stage never acts
  // on stale RegWrite/MemWrite/Branch bits.
  localparam logic CTRL_BUBBLE_BIT = 1'b0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  function automatic logic [1:0] state_to_occ(input stage_state_t st);
    logic [1:0] occ_v;
    case (st)
      ST_EMPTY: occ_v = 2'd0;
      ST_ONE:   occ_v = 2'd1;
      ST_TWO:   occ_v = 2'd2;
      default:  occ_v = 2'd0;
    endcase
    return occ_v;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload register (data + control) of the pipeline stage.
// Ports:
//   CLK, CLR_N         - clock and asynchronous active-low reset
//   load               - capture src_data/src_ctrl on the capture edge
//   clr_ctrl           - force the control field to the bubble value; the
//                        data field is kept (takes priority over load)
//   src_data, src_ctrl - payload to capture
//   data, ctrl         - stored payload
// CAPTURE_NEGEDGE selects the falling (1) or rising (0) CLK edge.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int CTRL_W          = CTRL_W_DEF,
  parameter bit CAPTURE_NEGEDGE = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [DATA_W-1:0] src_data,
  input  logic [CTRL_W-1:0] src_ctrl,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic [DATA_W-1:0] data_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_nxt_s;
  logic [CTRL_W-1:0] ctrl_nxt_s;

  // Next payload: clear control, load, or hold.
  always_comb begin
    data_nxt_s = data_r;
    ctrl_nxt_s = ctrl_r;
    if (clr_ctrl) begin
      data_nxt_s = data_r;
      ctrl_nxt_s = {CTRL_W{CTRL_BUBBLE_BIT}};
    end else if (load) begin
      data_nxt_s = src_data;
      ctrl_nxt_s = src_ctrl;
    end else begin
      data_nxt_s = data_r;
      ctrl_nxt_s = ctrl_r;
    end
  end

  generate
    if (CAPTURE_NEGEDGE) begin : g_neg
      // Payload register captured on the falling clock edge.
      always_ff @(negedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
          data_r <= {DATA_W{1'b0}};
          ctrl_r <= {CTRL_W{CTRL_BUBBLE_BIT}};
        end else begin
          data_r <= data_nxt_s;
          ctrl_r <= ctrl_nxt_s;
        end
      end
    end else begin : g_pos
      // Payload register captured on the rising clock edge.
      always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
          data_r <= {DATA_W{1'b0}};
          ctrl_r <= {CTRL_W{CTRL_BUBBLE_BIT}};
        end else begin
          data_r <= data_nxt_s;
          ctrl_r <= ctrl_nxt_s;
        end
      end
    end
  endgenerate

  assign data = data_r;
  assign ctrl = ctrl_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshake pipeline stage register with a 2-entry skid buffer.
// Ports:
//   CLK, CLR_N          - clock and asynchronous active-low reset
//   flush               - synchronous flush: stage empties on the next capture edge
//   in_valid/in_ready   - upstream handshake (in_ready depends only on state)
//   in_data, in_ctrl    - upstream payload
//   out_valid/out_ready - downstream handshake
//   out_data, out_ctrl  - head entry payload (out_ctrl is 0 when empty)
//   occ                 - number of held entries (0..2)
// The head ("main") entry always drives the outputs; the skid entry only
// holds a second entry accepted while downstream was stalled, so in_ready
// can be a pure function of state and still sustain one entry per cycle.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int CTRL_W          = CTRL_W_DEF,
  parameter bit CAPTURE_NEGEDGE = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  stage_state_t      state_r;
  stage_state_t      state_nxt_s;
  logic              in_ready_s;
  logic              out_valid_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              main_load_s;
  logic              main_clr_s;
  logic              main_from_skid_s;
  logic              skid_load_s;
  logic              skid_clr_s;
  logic [DATA_W-1:0] main_src_data_s;
  logic [CTRL_W-1:0] main_src_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;
  logic [CTRL_W-1:0] skid_ctrl_s;

  assign in_fire_s  = in_valid & in_ready_s;
  assign out_fire_s = out_valid_s & out_ready;

  generate
    if (CAPTURE_NEGEDGE) begin : g_state_neg
      // State register captured on the falling clock edge.
      always_ff @(negedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
          state_r <= ST_EMPTY;
        end else begin
          state_r <= state_nxt_s;
        end
      end
    end else begin : g_state_pos
      // State register captured on the rising clock edge.
      always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
          state_r <= ST_EMPTY;
        end else begin
          state_r <= state_nxt_s;
        end
      end
    end
  endgenerate

  // Next state and entry-register controls; flush overrides every fire.
  always_comb begin
    state_nxt_s      = state_r;
    main_load_s      = 1'b0;
    main_clr_s       = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clr_s       = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      main_clr_s  = 1'b1;
      skid_clr_s  = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = ST_ONE;
            main_load_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_nxt_s = ST_ONE;
            main_load_s = 1'b1;
          end else if (in_fire_s) begin
            // Head is stalled: park the new entry behind it.
            state_nxt_s = ST_TWO;
            skid_load_s = 1'b1;
          end else if (out_fire_s) begin
            state_nxt_s = ST_EMPTY;
            main_clr_s  = 1'b1;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire_s) begin
            state_nxt_s      = ST_ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_clr_s  = 1'b1;
          skid_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // Handshake and occupancy outputs decoded from the state register.
  always_comb begin
    in_ready_s  = CLR_N & (state_r != ST_TWO);
    out_valid_s = (state_r != ST_EMPTY);
    occ         = state_to_occ(state_r);
  end

  // Head refills from the skid entry when draining ST_TWO, else from upstream.
  always_comb begin
    if (main_from_skid_s) begin
      main_src_data_s = skid_data_s;
      main_src_ctrl_s = skid_ctrl_s;
    end else begin
      main_src_data_s = in_data;
      main_src_ctrl_s = in_ctrl;
    end
  end

  pipe_entry_reg #(
    .DATA_W         (DATA_W),
    .CTRL_W         (CTRL_W),
    .CAPTURE_NEGEDGE(CAPTURE_NEGEDGE)
  ) u_main (
    .CLK     (CLK),
    .CLR_N   (CLR_N),
    .load    (main_load_s),
    .clr_ctrl(main_clr_s),
    .src_data(main_src_data_s),
    .src_ctrl(main_src_ctrl_s),
    .data    (out_data),
    .ctrl    (out_ctrl)
  );

  pipe_entry_reg #(
    .DATA_W         (DATA_W),
    .CTRL_W         (CTRL_W),
    .CAPTURE_NEGEDGE(CAPTURE_NEGEDGE)
  ) u_skid (
    .CLK     (CLK),
    .CLR_N   (CLR_N),
    .load    (skid_load_s),
    .clr_ctrl(skid_clr_s),
    .src_data(in_data),
    .src_ctrl(in_ctrl),
    .data    (skid_data_s),
    .ctrl    (skid_ctrl_s)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, handshake-based pipeline stage register for the pipelined CPU. It is the successor to the fixed D/E stage latch and replaces that latch between any two stages. It adds a valid/ready handshake, a 2-entry skid buffer (full throughput with a registered in_ready), a working synchronous flush, and guaranteed zeroed control bits on bubbles. The payload is split into a data field (passed through) and a control field (forced to 0 whenever the stage holds no valid entry).

Parameters:
DATA_W, 32, width of data payload (operands, immediates, register addresses)
CTRL_W, 16, width of control payload (RegWrite, MemWrite, Branch, ALUControl, ...); zeroed on bubble
CAPTURE_NEGEDGE, 1, 1 = state updates on falling CLK edge; 0 = rising edge

Ports:
CLK  in  1  clock
CLR_N  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; empties the stage on the next capture edge
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
out_valid  out  1  stage holds a valid entry
out_ready  in  1  downstream accepts the entry
out_data  out  DATA_W  head-entry data
out_ctrl  out  CTRL_W  head-entry control; 0 when out_valid=0
occ  out  2  occupancy: 0, 1 or 2

Behaviour:
- Capture edge: negedge CLK if CAPTURE_NEGEDGE=1, else posedge. Reset is async on the falling edge of CLR_N in both modes.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready, both sampled at the capture edge.
- Storage: main entry (head) and skid entry. States are ST_EMPTY, ST_ONE and ST_TWO.
- Reset values while CLR_N=0:
  - state = ST_EMPTY, occ = 0, out_valid = 0, out_ctrl = 0, out_data = 0, skid = 0.
  - in_ready = 0 while CLR_N is low.
- Outputs:
  - in_ready = CLR_N & (state != ST_TWO). It depends only on state and reset, never combinationally on out_ready.
  - out_valid = (state != ST_EMPTY).
  - out_data and out_ctrl come from the main entry. The main control register is written to 0 whenever the stage becomes empty.
- Transitions when flush=0:
  - ST_EMPTY: in_fire -> ST_ONE, main <= in. Otherwise hold.
  - ST_ONE, in_fire & out_fire -> ST_ONE, main <= in.
  - ST_ONE, in_fire & !out_ready -> ST_TWO, skid <= in, main unchanged.
  - ST_ONE, !in_fire & out_fire -> ST_EMPTY, main.ctrl <= 0.
  - ST_ONE, neither fire -> hold.
  - ST_TWO: in_ready = 0. out_fire -> ST_ONE, main <= skid. Otherwise hold.
- Flush:
  - flush=1 at a capture edge -> ST_EMPTY, main.ctrl <= 0, skid.ctrl <= 0. Data fields are unchanged.
  - flush has priority over any in_fire in the same cycle; that entry is discarded, not accepted.
  - An out_fire coinciding with flush is treated as completed by downstream; the stage still empties.
- Latency and throughput:
  - 1 capture edge from in_fire to out_valid.
  - Sustained throughput is 1 entry/cycle while out_ready=1.
  - No entry is dropped or duplicated when out_ready toggles arbitrarily.
- Ordering: strict FIFO; the skid entry never overtakes main.
- occ equals 0, 1 or 2 for ST_EMPTY, ST_ONE and ST_TWO respectively; the value 3 never occurs.
- Reset mid-operation: all entries are lost immediately, asynchronously. The first accept can occur at the first capture edge after CLR_N rises.
- in_valid asserted while in_ready=0 has no effect. Upstream is not required to hold in_valid stable.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] stage_state_t {ST_EMPTY=0, ST_ONE=1, ST_TWO=2}.
  - Shared default widths DATA_W_DEF=32 and CTRL_W_DEF=16.
  - Bubble constant for the control field (all zero).
- Sub-module: pipe_entry_reg, one payload register with load enable and control-field clear. It is instantiated twice (main and skid), and the edge selection is done inside it via generate on CAPTURE_NEGEDGE.

Test Plan:
1. Reset and idle: CLR_N=0 -> in_ready=0, out_valid=0, out_ctrl=0, occ=0. Release CLR_N -> in_ready=1 on the next cycle.
2. Streaming: out_ready=1, feed in_data 0x11,0x22,0x33 on consecutive edges -> out_data 0x11,0x22,0x33 one edge later each; occ stays 1; no gaps.
3. Backpressure / skid:
   - Hold out_ready=0 while 0xA0 and 0xA1 are offered -> occ=2, in_ready=0, out_data=0xA0.
   - Raise out_ready -> 0xA0 then 0xA1 are delivered in order, and in_ready=1 after the first out_fire.
4. Flush with simultaneous input: occ=2, flush=1 with in_valid=1 (data 0xFF) -> next edge occ=0, out_valid=0, out_ctrl=0, and 0xFF is never output.
5. Async reset mid-stream: at occ=1, pulse CLR_N low between edges -> out_valid and out_ctrl drop to 0 immediately without waiting for a clock edge.
6. Edge mode: with CAPTURE_NEGEDGE=0, repeat scenario 2 -> out_valid changes only on rising CLK edges and the sequence is identical.
